// File: rtl/tlb_lookup_if.sv
// Bundle for the TLB lookup, response, write and INVTLB ports.
// Lookup handshake: a request transfers on a rising edge where lkp_valid & lkp_ready are both 1; the response appears exactly one cycle later with resp_valid=1.
interface tlb_lookup_if #(
  parameter int NUM_ENTRIES = 16,
  parameter int ASIDW       = 10
);
  localparam int IDXW = $clog2(NUM_ENTRIES);

  logic             lkp_valid;
  logic             lkp_ready;
  logic [31:0]      lkp_vaddr;
  logic [ASIDW-1:0] lkp_asid;

  logic             resp_valid;
  logic [19:0]      resp_pfn;
  logic             resp_ne;
  logic             resp_v;
  logic             resp_d;
  logic [1:0]       resp_plv;
  logic [IDXW-1:0]  resp_idx;

  logic             wr_en;
  logic [IDXW-1:0]  wr_idx;
  logic             wr_e;
  logic             wr_g;
  logic [ASIDW-1:0] wr_asid;
  logic [18:0]      wr_vppn;
  logic [23:0]      wr_lo0;
  logic [23:0]      wr_lo1;

  logic             inv_req;
  logic [2:0]       inv_op;
  logic [ASIDW-1:0] inv_asid;
  logic [18:0]      inv_vppn;
  logic             inv_busy;
  logic             inv_done;
  logic             inv_err;

  logic [1:0]       dbg_state;

  modport master (
    output lkp_valid, lkp_vaddr, lkp_asid,
    output wr_en, wr_idx, wr_e, wr_g, wr_asid, wr_vppn, wr_lo0, wr_lo1,
    output inv_req, inv_op, inv_asid, inv_vppn,
    input  lkp_ready, resp_valid, resp_pfn, resp_ne, resp_v, resp_d, resp_plv, resp_idx,
    input  inv_busy, inv_done, inv_err, dbg_state
  );

  modport slave (
    input  lkp_valid, lkp_vaddr, lkp_asid,
    input  wr_en, wr_idx, wr_e, wr_g, wr_asid, wr_vppn, wr_lo0, wr_lo1,
    input  inv_req, inv_op, inv_asid, inv_vppn,
    output lkp_ready, resp_valid, resp_pfn, resp_ne, resp_v, resp_d, resp_plv, resp_idx,
    output inv_busy, inv_done, inv_err, dbg_state
  );
endinterface

// File: rtl/tlb_lookup.sv
// Fully-associative TLB: registered lookup, entry write port and a one-entry-per-cycle INVTLB sweep.
module tlb_lookup #(
  parameter int NUM_ENTRIES = 16,
  parameter int ASIDW       = 10
) (
  input  logic         clk,
  input  logic         resetn,
  tlb_lookup_if.slave  bus
);
  localparam int IDXW = $clog2(NUM_ENTRIES);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SWEEP = 2'd1, S_DONE = 2'd2} state_t;

  state_t           r_state;
  logic [IDXW-1:0]  r_ptr;
  logic [2:0]       r_op;
  logic [ASIDW-1:0] r_inv_asid;
  logic [18:0]      r_inv_vppn;
  logic             r_busy, r_done, r_err;

  logic [NUM_ENTRIES-1:0] r_e, r_g;
  logic [ASIDW-1:0]       r_asid [NUM_ENTRIES];
  logic [18:0]            r_vppn [NUM_ENTRIES];
  logic [23:0]            r_lo0  [NUM_ENTRIES];
  logic [23:0]            r_lo1  [NUM_ENTRIES];

  logic             r_resp_valid, r_resp_ne, r_resp_v, r_resp_d;
  logic [19:0]      r_resp_pfn;
  logic [1:0]       r_resp_plv;
  logic [IDXW-1:0]  r_resp_idx;

  logic [NUM_ENTRIES-1:0] w_hit;
  logic                   w_hit_any;
  logic [IDXW-1:0]        w_hit_idx;
  logic [23:0]            w_lo;
  logic                   w_accept;
  logic                   w_inv_match;
  logic                   w_asid_eq, w_vppn_eq, w_g;

  assign bus.lkp_ready = resetn & (r_state != S_SWEEP);
  assign w_accept      = bus.lkp_valid & bus.lkp_ready;

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_hit[i] = r_e[i] && (r_vppn[i] == bus.lkp_vaddr[31:13]) &&
                 (r_g[i] || (r_asid[i] == bus.lkp_asid));
    end
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    w_hit_any = 1'b0;
    w_hit_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_hit_any = 1'b1;
        w_hit_idx = IDXW'(i);
      end
    end
  end

  assign w_lo = bus.lkp_vaddr[12] ? r_lo1[w_hit_idx] : r_lo0[w_hit_idx];

  assign w_g       = r_g[r_ptr];
  assign w_asid_eq = (r_asid[r_ptr] == r_inv_asid);
  assign w_vppn_eq = (r_vppn[r_ptr] == r_inv_vppn);

  always_comb begin
    w_inv_match = 1'b0;
    case (r_op)
      3'd0, 3'd1: w_inv_match = 1'b1;
      3'd2:       w_inv_match = w_g;
      3'd3:       w_inv_match = ~w_g;
      3'd4:       w_inv_match = ~w_g & w_asid_eq;
      3'd5:       w_inv_match = ~w_g & w_asid_eq & w_vppn_eq;
      3'd6:       w_inv_match = (w_g | w_asid_eq) & w_vppn_eq;
      default:    w_inv_match = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_op       <= '0;
      r_inv_asid <= '0;
      r_inv_vppn <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.inv_req) begin
            if (bus.inv_op == 3'd7) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state    <= S_SWEEP;
              r_busy     <= 1'b1;
              r_ptr      <= '0;
              r_op       <= bus.inv_op;
              r_inv_asid <= bus.inv_asid;
              r_inv_vppn <= bus.inv_vppn;
            end
          end
        end
        S_SWEEP: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == IDXW'(NUM_ENTRIES - 1)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A write to the entry under the sweep pointer takes priority over its clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_e <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (bus.wr_en && (bus.wr_idx == IDXW'(i)))
          r_e[i] <= bus.wr_e;
        else if ((r_state == S_SWEEP) && (r_ptr == IDXW'(i)) && w_inv_match)
          r_e[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      r_g[bus.wr_idx]    <= bus.wr_g;
      r_asid[bus.wr_idx] <= bus.wr_asid;
      r_vppn[bus.wr_idx] <= bus.wr_vppn;
      r_lo0[bus.wr_idx]  <= bus.wr_lo0;
      r_lo1[bus.wr_idx]  <= bus.wr_lo1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_resp_valid <= 1'b0;
      r_resp_ne    <= 1'b0;
      r_resp_pfn   <= '0;
      r_resp_v     <= 1'b0;
      r_resp_d     <= 1'b0;
      r_resp_plv   <= '0;
      r_resp_idx   <= '0;
    end else begin
      r_resp_valid <= w_accept;
      if (w_accept) begin
        r_resp_ne  <= ~w_hit_any;
        r_resp_pfn <= w_hit_any ? w_lo[23:4] : 20'd0;
        r_resp_plv <= w_hit_any ? w_lo[3:2]  : 2'd0;
        r_resp_d   <= w_hit_any & w_lo[1];
        r_resp_v   <= w_hit_any & w_lo[0];
        r_resp_idx <= w_hit_any ? w_hit_idx : '0;
      end
    end
  end

  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_ne    = r_resp_ne;
  assign bus.resp_pfn   = r_resp_pfn;
  assign bus.resp_v     = r_resp_v;
  assign bus.resp_d     = r_resp_d;
  assign bus.resp_plv   = r_resp_plv;
  assign bus.resp_idx   = r_resp_idx;
  assign bus.inv_busy   = r_busy;
  assign bus.inv_done   = r_done;
  assign bus.inv_err    = r_err;
  assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_tlb_lookup.sv
// Randomized and directed bench for tlb_lookup against an array-based TLB model.
module tb_tlb_lookup;
  localparam int N     = 16;
  localparam int ASIDW = 10;
  localparam int IDXW  = $clog2(N);

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  tlb_lookup_if #(.NUM_ENTRIES(N), .ASIDW(ASIDW)) bus ();
  tlb_lookup #(.NUM_ENTRIES(N), .ASIDW(ASIDW)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  // Reference TLB contents
  bit          m_e [N];
  bit          m_g [N];
  int unsigned m_asid [N];
  int unsigned m_vppn [N];
  logic [23:0] m_lo0 [N];
  logic [23:0] m_lo1 [N];

  // {ne, idx, pfn, plv, d, v}
  logic [28:0] exp_q[$];
  logic [19:0] last_pfn;

  int unsigned asid_pool [3] = '{5, 6, 7};
  int unsigned vppn_pool [4] = '{32'h12345, 32'h00001, 32'h7FFFF, 32'h2AAAA};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.lkp_valid = 1'b0;
    bus.wr_en     = 1'b0;
    bus.inv_req   = 1'b0;
  endtask

  function automatic logic [28:0] model_lookup(input logic [31:0] va, input int unsigned asid);
    logic [23:0] lo;
    for (int i = 0; i < N; i++) begin
      if (m_e[i] && m_vppn[i] == int'(va[31:13]) && (m_g[i] || m_asid[i] == asid)) begin
        lo = va[12] ? m_lo1[i] : m_lo0[i];
        return {1'b0, 4'(i), lo};
      end
    end
    return {1'b1, 28'd0};
  endfunction

  function automatic bit inv_hits(input int i, input int op, input int unsigned asid,
                                  input int unsigned vppn);
    bit a = (m_asid[i] == asid);
    bit v = (m_vppn[i] == vppn);
    case (op)
      0, 1:    return 1'b1;
      2:       return m_g[i];
      3:       return !m_g[i];
      4:       return !m_g[i] && a;
      5:       return !m_g[i] && a && v;
      6:       return (m_g[i] || a) && v;
      default: return 1'b0;
    endcase
  endfunction

  task automatic start_lookup(input logic [31:0] va, input int unsigned asid);
    bus.lkp_valid = 1'b1;
    bus.lkp_vaddr = va;
    bus.lkp_asid  = ASIDW'(asid);
    exp_q.push_back(model_lookup(va, asid));
  endtask

  task automatic drive_wr(input int idx, input bit e, input bit g, input int unsigned asid,
                          input int unsigned vppn, input logic [23:0] lo0, input logic [23:0] lo1);
    bus.wr_en   = 1'b1;
    bus.wr_idx  = IDXW'(idx);
    bus.wr_e    = e;
    bus.wr_g    = g;
    bus.wr_asid = ASIDW'(asid);
    bus.wr_vppn = 19'(vppn);
    bus.wr_lo0  = lo0;
    bus.wr_lo1  = lo1;
    m_e[idx] = e;  m_g[idx] = g;  m_asid[idx] = asid;  m_vppn[idx] = vppn;
    m_lo0[idx] = lo0;  m_lo1[idx] = lo1;
  endtask

  task automatic check_resp(input string tag);
    logic [28:0] ex;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
      return;
    end
    ex = exp_q.pop_front();
    check({tag, "_valid"}, 32'(bus.resp_valid), 32'd1);
    check({tag, "_ne"},    32'(bus.resp_ne),    32'(ex[28]));
    check({tag, "_idx"},   32'(bus.resp_idx),   32'(ex[27:24]));
    check({tag, "_pfn"},   32'(bus.resp_pfn),   32'(ex[23:4]));
    check({tag, "_attr"},  32'({bus.resp_plv, bus.resp_d, bus.resp_v}), 32'(ex[3:0]));
    last_pfn = ex[23:4];
  endtask

  task automatic write(input int idx, input bit e, input bit g, input int unsigned asid,
                       input int unsigned vppn, input logic [23:0] lo0, input logic [23:0] lo1);
    drive_wr(idx, e, g, asid, vppn, lo0, lo1);
    tick();
    idle_inputs();
  endtask

  task automatic lookup(input string tag, input logic [31:0] va, input int unsigned asid);
    start_lookup(va, asid);
    tick();
    idle_inputs();
    check_resp(tag);
  endtask

  // Runs one INVTLB; wr_at >= 0 writes a live entry to that index while the pointer is on it.
  task automatic run_inv(input string tag, input int op, input int unsigned asid,
                         input int unsigned vppn, input int wr_at);
    int cyc = 1;
    int n_busy = 0;
    int n_ready = 0;
    bus.inv_req  = 1'b1;
    bus.inv_op   = 3'(op);
    bus.inv_asid = ASIDW'(asid);
    bus.inv_vppn = 19'(vppn);
    tick();
    idle_inputs();
    if (op != 7)
      for (int i = 0; i < N; i++) if (inv_hits(i, op, asid, vppn)) m_e[i] = 1'b0;
    while (cyc < 40 && !bus.inv_done) begin
      if (bus.inv_busy) n_busy++;
      if (bus.inv_busy && bus.lkp_ready) n_ready++;
      if (wr_at >= 0 && cyc == wr_at + 1)
        drive_wr(wr_at, 1'b1, 1'b0, asid, vppn, 24'h0, 24'h55555F);
      tick();
      bus.wr_en = 1'b0;
      cyc++;
    end
    check({tag, "_done_cycle"}, 32'(cyc), (op == 7) ? 32'd1 : 32'(N + 1));
    check({tag, "_busy_cycles"}, 32'(n_busy), (op == 7) ? 32'd0 : 32'(N));
    check({tag, "_ready_low"}, 32'(n_ready), 32'd0);
    check({tag, "_err"}, 32'(bus.inv_err), (op == 7) ? 32'd1 : 32'd0);
    tick();
    check({tag, "_done_pulse"}, 32'(bus.inv_done), 32'd0);
    check({tag, "_idle"}, 32'(bus.dbg_state), 32'd0);
  endtask

  initial begin
    logic [31:0] va;
    int done_seen;
    idle_inputs();
    bus.lkp_vaddr = '0; bus.lkp_asid = '0;
    bus.wr_idx = '0; bus.wr_e = 0; bus.wr_g = 0; bus.wr_asid = '0;
    bus.wr_vppn = '0; bus.wr_lo0 = '0; bus.wr_lo1 = '0;
    bus.inv_op = '0; bus.inv_asid = '0; bus.inv_vppn = '0;
    for (int i = 0; i < N; i++) begin
      m_e[i] = 0; m_g[i] = 0; m_asid[i] = 0; m_vppn[i] = 0; m_lo0[i] = '0; m_lo1[i] = '0;
    end

    #12;
    check("rst_ready", 32'(bus.lkp_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    resetn = 1'b1;
    tick();
    check("rst_ready_after", 32'(bus.lkp_ready), 32'd1);
    check("rst_busy", 32'(bus.inv_busy), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'd0);
    lookup("rst_miss", 32'h2468B000, 5);

    // T1
    write(3, 1, 0, 5, 32'h12345, 24'h000000, {20'hABCDE, 2'b00, 1'b0, 1'b1});
    lookup("t1_hit", 32'h2468B000, 5);
    tick();
    check("hold_valid", 32'(bus.resp_valid), 32'd0);
    check("hold_pfn", 32'(bus.resp_pfn), 32'(last_pfn));
    lookup("t1_even", 32'h2468A000, 5);

    // T2
    lookup("t2_asid_miss", 32'h2468B000, 6);
    write(3, 1, 1, 5, 32'h12345, 24'h000000, {20'hABCDE, 2'b00, 1'b0, 1'b1});
    lookup("t2_global", 32'h2468B000, 6);

    // T3
    write(2, 1, 0, 5, 32'h00001, 24'h11111B, 24'h22222E);
    write(9, 1, 0, 5, 32'h00001, 24'h33333F, 24'h444447);
    start_lookup(32'h00002000, 5);
    drive_wr(2, 0, 0, 5, 32'h00001, 24'h0, 24'h0);
    tick();
    idle_inputs();
    check_resp("t3_old_data");
    lookup("t3_next", 32'h00002000, 5);

    // T4 with a mix of entries
    write(4, 1, 0, 5, 32'h7FFFF, 24'h0ABCD5, 24'h0);
    write(5, 1, 0, 6, 32'h7FFFF, 24'h0DCBA5, 24'h0);
    write(6, 1, 1, 5, 32'h2AAAA, 24'h0F0F05, 24'h0);
    run_inv("t4", 4, 5, 0, -1);
    lookup("t4_g0_a5", 32'hFFFFE000, 5);
    lookup("t4_g0_a6", 32'hFFFFE000, 6);
    lookup("t4_global", 32'h55554000, 5);
    lookup("t4_idx9", 32'h00002000, 5);

    // Write to the entry under the pointer survives the sweep
    write(7, 1, 0, 7, 32'h2AAAA, 24'h0, 24'h123451);
    run_inv("wr_sweep", 0, 7, 32'h2AAAA, 7);
    lookup("wr_sweep_keep", 32'h55555000, 7);
    lookup("wr_sweep_gone", 32'h2468B000, 5);

    // T5: illegal op
    write(1, 1, 0, 5, 32'h00001, 24'h0, 24'h777771);
    run_inv("t5_illegal", 7, 5, 32'h00001, -1);
    lookup("t5_kept", 32'h00003000, 5);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      int kind = $urandom_range(0, 9);
      va = {13'(vppn_pool[$urandom_range(0, 3)]), 1'($urandom_range(0, 1)), 12'($urandom)};
      if (kind < 4)
        write($urandom_range(0, N - 1), $urandom_range(0, 3) != 0, $urandom_range(0, 1),
              asid_pool[$urandom_range(0, 2)], vppn_pool[$urandom_range(0, 3)],
              24'($urandom), 24'($urandom));
      else if (kind == 9)
        run_inv("rnd_inv", $urandom_range(0, 6), asid_pool[$urandom_range(0, 2)],
                vppn_pool[$urandom_range(0, 3)], -1);
      else
        lookup("rnd", {va[31:13], va[12:0]}, asid_pool[$urandom_range(0, 2)]);
    end

    // Reset in the middle of a sweep
    for (int i = 0; i < 4; i++) write(i, 1, 1, 5, 32'h12345, 24'h0, 24'h000011);
    bus.inv_req = 1'b1; bus.inv_op = 3'd3; bus.inv_asid = 10'd5; bus.inv_vppn = '0;
    tick();
    idle_inputs();
    repeat (5) tick();
    resetn = 1'b0;
    #2;
    check("mid_rst_busy", 32'(bus.inv_busy), 32'd0);
    check("mid_rst_state", 32'(bus.dbg_state), 32'd0);
    for (int i = 0; i < N; i++) m_e[i] = 0;
    tick();
    resetn = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.inv_done) done_seen++;
      tick();
    end
    check("mid_rst_no_done", 32'(done_seen), 32'd0);
    check("mid_rst_ready", 32'(bus.lkp_ready), 32'd1);
    lookup("mid_rst_miss", 32'h2468B000, 5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
